// File: rtl/ball_engine.sv
// Pong game-state engine: once per frame tick it moves the ball, resolves
// wall/paddle bounces and misses, and keeps both scores.
module ball_engine #(
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int X_POS_W       = 10,
  parameter int Y_POS_W       = 10,
  parameter int BALL_SIDE     = 8,
  parameter int PADDLE_WIDTH  = 8,
  parameter int PADDLE_HEIGHT = 64,
  parameter int PLAYER_X      = 16,
  parameter int PC_X          = 616,
  parameter int SPEED         = 2,
  parameter int SERVE_DELAY   = 60,
  parameter int WIN_SCORE     = 7
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               new_frame_i,
  input  logic               restart_i,
  input  logic [Y_POS_W-1:0] player_paddle_y_i,
  input  logic [Y_POS_W-1:0] pc_paddle_y_i,
  output logic [X_POS_W-1:0] ball_x_o,
  output logic [Y_POS_W-1:0] ball_y_o,
  output logic [3:0]         player_score_o,
  output logic [3:0]         pc_score_o,
  output logic               ball_hit_o,
  output logic               point_o,
  output logic               game_over_o
);

  localparam int XW    = X_POS_W + 1;
  localparam int YW    = Y_POS_W + 1;
  localparam int CNT_W = $clog2(SERVE_DELAY + 1);

  localparam logic [X_POS_W-1:0] CX       = X_POS_W'(H_RES / 2 - BALL_SIDE / 2);
  localparam logic [Y_POS_W-1:0] CY       = Y_POS_W'(V_RES / 2 - BALL_SIDE / 2);
  localparam logic [X_POS_W-1:0] X_PL_HIT = X_POS_W'(PLAYER_X + PADDLE_WIDTH);
  localparam logic [X_POS_W-1:0] X_PC_HIT = X_POS_W'(PC_X - BALL_SIDE);
  localparam logic [Y_POS_W-1:0] Y_BOTTOM = Y_POS_W'(V_RES - BALL_SIDE);

  localparam logic [XW-1:0] SPD_X   = XW'(SPEED);
  localparam logic [XW-1:0] BS_X    = XW'(BALL_SIDE);
  localparam logic [XW-1:0] PL_EDGE = XW'(PLAYER_X + PADDLE_WIDTH);
  localparam logic [XW-1:0] PC_EDGE = XW'(PC_X);
  localparam logic [XW-1:0] HRES_X  = XW'(H_RES);
  localparam logic [YW-1:0] SPD_Y   = YW'(SPEED);
  localparam logic [YW-1:0] BS_Y    = YW'(BALL_SIDE);
  localparam logic [YW-1:0] PH_Y    = YW'(PADDLE_HEIGHT);
  localparam logic [YW-1:0] VRES_Y  = YW'(V_RES);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [X_POS_W-1:0] x_q;
  logic [Y_POS_W-1:0] y_q;
  logic               dx_q;  // 1 = moving right
  logic               dy_q;  // 1 = moving down
  logic [3:0]         pscore_q;
  logic [3:0]         cscore_q;
  logic               hit_q;
  logic               point_q;
  logic               over_q;

  logic [XW-1:0]      xe_s;
  logic [XW-1:0]      nx_s;
  logic [YW-1:0]      ye_s;
  logic [Y_POS_W-1:0] ny_s;
  logic [YW-1:0]      ppy_s;
  logic [YW-1:0]      cpy_s;
  logic               ov_player_s;
  logic               ov_pc_s;
  logic               hit_player_s;
  logic               hit_pc_s;
  logic               miss_left_s;
  logic               miss_right_s;
  logic               wall_top_s;
  logic               wall_bot_s;
  logic [X_POS_W-1:0] x_d;
  logic [Y_POS_W-1:0] y_d;
  logic               dx_d;
  logic               dy_d;
  logic [3:0]         pscore_d;
  logic [3:0]         cscore_d;

  // Candidate motion and collision resolution for one PLAY tick
  always_comb begin
    xe_s  = {1'b0, x_q};
    ye_s  = {1'b0, y_q};
    ppy_s = {1'b0, player_paddle_y_i};
    cpy_s = {1'b0, pc_paddle_y_i};

    if (dx_q) begin
      nx_s = xe_s + SPD_X;
    end else begin
      nx_s = xe_s - SPD_X;
    end
    // Any wrap of the candidate is masked by a wall, paddle or miss below
    if (dy_q) begin
      ny_s = y_q + Y_POS_W'(SPEED);
    end else begin
      ny_s = y_q - Y_POS_W'(SPEED);
    end

    ov_player_s  = (ye_s + BS_Y > ppy_s) && (ye_s < ppy_s + PH_Y);
    ov_pc_s      = (ye_s + BS_Y > cpy_s) && (ye_s < cpy_s + PH_Y);
    hit_player_s = !dx_q && (xe_s >= PL_EDGE) && (nx_s < PL_EDGE) && ov_player_s;
    hit_pc_s     = dx_q && (xe_s + BS_X <= PC_EDGE) && (nx_s + BS_X > PC_EDGE) && ov_pc_s;
    miss_left_s  = !dx_q && (xe_s < SPD_X) && !hit_player_s;
    miss_right_s = dx_q && (xe_s + BS_X + SPD_X >= HRES_X) && !hit_pc_s;
    wall_top_s   = !dy_q && (ye_s <= SPD_Y);
    wall_bot_s   = dy_q && (ye_s + BS_Y + SPD_Y >= VRES_Y);

    if (hit_player_s) begin
      x_d  = X_PL_HIT;
      dx_d = 1'b1;
    end else if (hit_pc_s) begin
      x_d  = X_PC_HIT;
      dx_d = 1'b0;
    end else begin
      x_d  = nx_s[X_POS_W-1:0];
      dx_d = dx_q;
    end

    if (wall_top_s) begin
      y_d  = '0;
      dy_d = 1'b1;
    end else if (wall_bot_s) begin
      y_d  = Y_BOTTOM;
      dy_d = 1'b0;
    end else begin
      y_d  = ny_s;
      dy_d = dy_q;
    end

    pscore_d = (pscore_q == 4'd15) ? 4'd15 : pscore_q + 4'd1;
    cscore_d = (cscore_q == 4'd15) ? 4'd15 : cscore_q + 4'd1;
  end

  // Game FSM: every state and output register advances only on a frame tick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= SERVE;
      cnt_q    <= '0;
      x_q      <= CX;
      y_q      <= CY;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      pscore_q <= 4'd0;
      cscore_q <= 4'd0;
      hit_q    <= 1'b0;
      point_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      hit_q   <= 1'b0;
      point_q <= 1'b0;
      if (new_frame_i) begin
        case (state_q)
          SERVE: begin
            if (cnt_q == CNT_W'(SERVE_DELAY - 1)) begin
              cnt_q   <= '0;
              state_q <= PLAY;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          PLAY: begin
            if (miss_left_s || miss_right_s) begin
              x_q     <= CX;
              y_q     <= CY;
              dy_q    <= 1'b1;
              point_q <= 1'b1;
              cnt_q   <= '0;
              if (miss_left_s) begin
                cscore_q <= cscore_d;
                dx_q     <= 1'b0;
                if (cscore_d == 4'(WIN_SCORE)) begin
                  state_q <= OVER;
                  over_q  <= 1'b1;
                end else begin
                  state_q <= SERVE;
                end
              end else begin
                pscore_q <= pscore_d;
                dx_q     <= 1'b1;
                if (pscore_d == 4'(WIN_SCORE)) begin
                  state_q <= OVER;
                  over_q  <= 1'b1;
                end else begin
                  state_q <= SERVE;
                end
              end
            end else begin
              x_q   <= x_d;
              y_q   <= y_d;
              dx_q  <= dx_d;
              dy_q  <= dy_d;
              hit_q <= hit_player_s || hit_pc_s;
            end
          end
          OVER: begin
            if (restart_i) begin
              state_q  <= SERVE;
              cnt_q    <= '0;
              pscore_q <= 4'd0;
              cscore_q <= 4'd0;
              over_q   <= 1'b0;
              dx_q     <= 1'b1;
              dy_q     <= 1'b1;
              x_q      <= CX;
              y_q      <= CY;
            end else begin
              over_q <= 1'b1;
            end
          end
          default: begin
            state_q <= SERVE;
          end
        endcase
      end
    end
  end

  assign ball_x_o       = x_q;
  assign ball_y_o       = y_q;
  assign player_score_o = pscore_q;
  assign pc_score_o     = cscore_q;
  assign ball_hit_o     = hit_q;
  assign point_o        = point_q;
  assign game_over_o    = over_q;

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Game-state producer for the position interface that the VGA display consumes.
- Once per frame (on the display's one-cycle new-frame pulse) it advances the ball, resolves wall and paddle collisions, detects misses, and keeps scores.
- Drives the ball coordinates and scores back to the display and score logic.
- Player/PC paddle Y positions come from the paddle controllers; paddle X positions are fixed parameters.

Parameters:
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- X_POS_W, 10, X coordinate width
- Y_POS_W, 10, Y coordinate width
- BALL_SIDE, 8, ball square side
- PADDLE_WIDTH, 8, paddle width
- PADDLE_HEIGHT, 64, paddle height
- PLAYER_X, 16, player paddle left edge
- PC_X, 616, PC paddle left edge
- SPEED, 2, pixels moved per frame on each axis
- SERVE_DELAY, 60, frames held at centre before a serve
- WIN_SCORE, 7, score that ends the game

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- new_frame_i  in  1  one-cycle frame-tick pulse
- restart_i  in  1  level; honoured only in OVER
- player_paddle_y_i  in  Y_POS_W  player paddle top edge
- pc_paddle_y_i  in  Y_POS_W  PC paddle top edge
- ball_x_o  out  X_POS_W  ball left edge
- ball_y_o  out  Y_POS_W  ball top edge
- player_score_o  out  4  player points
- pc_score_o  out  4  PC points
- ball_hit_o  out  1  one-cycle pulse on a paddle bounce
- point_o  out  1  one-cycle pulse on a miss
- game_over_o  out  1  high while in OVER

Behaviour:
- Reset (async assert, sync release):
  - ball = centre, CX = H_RES/2 - BALL_SIDE/2 = 316, CY = V_RES/2 - BALL_SIDE/2 = 236.
  - Scores 0, all pulses 0, game_over_o 0.
  - state SERVE, serve counter 0, dx = right, dy = down.
  - Reset mid-play aborts immediately to this state.
- All outputs are registered. State changes only on clock edges where new_frame_i = 1, and are visible the following cycle.
- The display latches old values on its tick, giving a fixed one-frame lag. This is accepted.
- Pulses (ball_hit_o, point_o) last exactly one cycle; otherwise 0.
- SERVE:
  - Ball held at (CX, CY).
  - Counter +1 per tick. On the tick where counter == SERVE_DELAY-1: counter cleared, go PLAY, position unchanged that tick.
- PLAY, per tick:
  - Arithmetic in X_POS_W+1 / Y_POS_W+1 bits; no wrap permitted.
  - Candidate position: nx = x ± SPEED, ny = y ± SPEED.
  - Top wall: moving up and y <= SPEED → y = 0, dy = down.
  - Bottom wall: moving down and y + BALL_SIDE + SPEED >= V_RES → y = V_RES - BALL_SIDE, dy = up.
  - Vertical overlap with a paddle at py means y + BALL_SIDE > py and y < py + PADDLE_HEIGHT, using the current y.
  - Player paddle: moving left, x >= PLAYER_X + PADDLE_WIDTH, nx < PLAYER_X + PADDLE_WIDTH, overlap → x = PLAYER_X + PADDLE_WIDTH, dx = right, ball_hit_o.
  - PC paddle: moving right, x + BALL_SIDE <= PC_X, nx + BALL_SIDE > PC_X, overlap → x = PC_X - BALL_SIDE, dx = left, ball_hit_o.
  - Left miss: moving left and x < SPEED (no paddle hit) → pc_score +1, point_o, dx = left for the next serve.
  - Right miss: moving right and x + BALL_SIDE + SPEED >= H_RES (no hit) → player_score +1, point_o, dx = right for the next serve.
  - After a miss: ball to centre, dy = down, go SERVE. If the new score == WIN_SCORE, go OVER instead.
  - Wall and paddle resolution in the same tick are applied together, independently per axis.
  - A paddle hit takes priority over a miss.
- OVER:
  - Ball at centre, scores frozen, game_over_o = 1.
  - restart_i = 1 on a tick → scores 0, game_over_o 0, SERVE, dx = right.
- restart_i is ignored outside OVER.
- Scores saturate at 15; WIN_SCORE < 16 is required.

Test Plan:
- Reset, then 60 ticks → ball stays (316,236), no pulses. 61st tick → (318,238).
- new_frame_i held low for 1000 cycles mid-PLAY → all outputs frozen.
- Serve, 117 PLAY ticks → ball (550,470). Next tick → (552,472), dy = up. Following tick → y = 470.
- pc_paddle_y_i = 400; ball reaches (608,416) moving right-up → next tick (608,414), ball_hit_o one cycle. Following tick → x = 606.
- pc_paddle_y_i = 0 → ball passes the paddle:
  - On the tick where x + 8 + 2 >= 640: player_score_o = 1, point_o one cycle, ball at (316,236).
  - After 60 ticks the serve moves right.
- Drive 7 right misses → game_over_o = 1 and the ball stays at centre. restart_i on a tick → scores 0, SERVE. Assert rst_ni low mid-flight → outputs at reset values immediately, without a clock edge.
